ex_stage: RTL
=============

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  in  1  rising-edge clock; sole clock.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 StallE  in  1  hold all E-stage registers.
REQ-004 FlushE  in  1  load bubble into E-stage registers.
REQ-005 ValidD  in  1  decode slot holds a real instruction.
REQ-006 RegWriteD, MemWriteD, JumpD, BranchD  in  1 each  decode control bits.
REQ-007 ResultSrcD  in  2  writeback select, passed through.
REQ-008 ALUControlD  in  4  decoded ALU operation.
REQ-009 ALUSrcD  in  2  bit0: SrcB=immediate; bit1: SrcA=PC.
REQ-010 funct3D  in  3  branch condition select.
REQ-011 RD1D, RD2D, PCD, ImmExtD, PCPlus4D  in  32 each  decode data.
REQ-012 Rs1D, Rs2D, RdD  in  5 each  register addresses.
REQ-013 ForwardAE, ForwardBE  in  2 each  00 register, 10 ALUResultM, 01 ResultW.
REQ-014 ALUResultM, ResultW  in  32 each  forwarding sources.
REQ-015 ValidE, RegWriteE, MemWriteE  out  1 each  registered controls, gated by ValidE.
REQ-016 ResultSrcE  out  2;  Rs1E, Rs2E, RdE  out  5 each  registered fields.
REQ-017 ALUResultE, WriteDataE, PCTargetE, PCPlus4E  out  32 each  execute results.
REQ-018 PCSrcE  out  1  redirect fetch (taken branch or jump).

Function
REQ-019 Each rising clk: reset, else FlushE, else StallE, else load all D inputs into E registers; priority in that order.
REQ-020 Flush loads zeros into every E register (ValidE=0, bubble); flush with simultaneous stall still flushes.
REQ-021 Stall holds every E register unchanged, including ValidE.
REQ-022 SrcA = PCE if ALUSrcE[1], else forwarded A; SrcB = ImmExtE if ALUSrcE[0], else forwarded B.
REQ-023 WriteDataE = forwarded B, independent of ALUSrcE; ForwardxE=11 treated as 00.
REQ-024 ALU (32-bit, combinational from E registers): 0000 add; 0001 sub; 0010 and; 0011 or; 0100 xor; 0101 signed slt (0/1); 0110 sll; 0111 srl; 1000 sra; 1001 unsigned sltu; 1011 pass SrcB (lui); 1100 SrcA+SrcB (auipc); all other codes give 0.
REQ-025 Shifts use SrcB[4:0] only; add/sub wrap modulo 2^32, no overflow flag.
REQ-026 Zero = (ALUResultE==0); cond by funct3E: 000 Zero, 001 !Zero, 100/110 ALUResultE[0], 101/111 !ALUResultE[0], others 0.
REQ-027 PCSrcE = ValidE & (JumpE | (BranchE & cond)); PCTargetE = PCE+ImmExtE.
REQ-028 RegWriteE/MemWriteE outputs are 0 when ValidE=0.
REQ-029 Latency: D inputs appear at E outputs one cycle after capture; results combinational within the cycle.

Reset
REQ-030 Synchronous reset zeroes every E register; all outputs 0, PCSrcE=0, ValidE=0 on the edge after reset asserted.
REQ-031 Reset mid-stall or mid-flush overrides both; no E state survives reset.

Configuration
REQ-032 FORWARDING_EN defined: forwarding muxes per REQ-013.
REQ-033 FORWARDING_EN undefined: ForwardAE/ForwardBE/ALUResultM/ResultW ignored; operands always RD1E/RD2E.

Verification
REQ-034 add: RD1D=7, RD2D=5, ALUControlD=0000, ALUSrcD=00, ValidD=1 -> next cycle ALUResultE=12.
REQ-035 sra: RD1D=0x80000000, ImmExtD=4, ALUControlD=1000, ALUSrcD=01 -> ALUResultE=0xF8000000.
REQ-036 beq taken: RD1D=RD2D=9, ALUControlD=0001, BranchD=1, funct3D=000, PCD=0x100, ImmExtD=0x20 -> PCSrcE=1, PCTargetE=0x120.
REQ-037 forward: ForwardAE=10, ALUResultM=3, RD2D=4, add (FORWARDING_EN defined) -> ALUResultE=7; with macro undefined and RD1D=1 -> 5.
REQ-038 StallE and FlushE together with JumpD=1 -> ValidE=0, PCSrcE=0; StallE alone for 3 cycles -> outputs unchanged.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage of a five-stage RV32 pipeline.
//
// The module holds the D->E pipeline register and evaluates everything
// that depends on it within the cycle:
// - operand forwarding
// - ALU
// - branch condition
// - branch target
// - fetch redirect
//
// Configuration macro: FORWARDING_EN
//   defined   : ALU operands come from the forwarding muxes driven by
//               ForwardAE/ForwardBE.
//   undefined : the forwarding ports are ignored and the operands are
//               always RD1E/RD2E.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   StallE, FlushE        hold / bubble the E registers (flush wins)
//   ValidD, *D            decode-stage instruction fields
//   ForwardAE/BE          operand select: 00 reg, 10 ALUResultM, 01 ResultW
//                         (11 behaves as 00)
//   ALUResultM, ResultW   forwarding sources
//   ValidE ... PCPlus4E   registered E-stage fields and execute results
//   PCSrcE                redirect fetch to PCTargetE
module ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallE,
  input  logic        FlushE,
  input  logic        ValidD,
  input  logic        RegWriteD,
  input  logic        MemWriteD,
  input  logic        JumpD,
  input  logic        BranchD,
  input  logic [1:0]  ResultSrcD,
  input  logic [3:0]  ALUControlD,
  input  logic [1:0]  ALUSrcD,
  input  logic [2:0]  funct3D,
  input  logic [31:0] RD1D,
  input  logic [31:0] RD2D,
  input  logic [31:0] PCD,
  input  logic [31:0] ImmExtD,
  input  logic [31:0] PCPlus4D,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  RdD,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] ResultW,
  output logic        ValidE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic [1:0]  ResultSrcE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic [31:0] ALUResultE,
  output logic [31:0] WriteDataE,
  output logic [31:0] PCTargetE,
  output logic [31:0] PCPlus4E,
  output logic        PCSrcE
);

  localparam logic [3:0] AluAdd   = 4'b0000;
  localparam logic [3:0] AluSub   = 4'b0001;
  localparam logic [3:0] AluAnd   = 4'b0010;
  localparam logic [3:0] AluOr    = 4'b0011;
  localparam logic [3:0] AluXor   = 4'b0100;
  localparam logic [3:0] AluSlt   = 4'b0101;
  localparam logic [3:0] AluSll   = 4'b0110;
  localparam logic [3:0] AluSrl   = 4'b0111;
  localparam logic [3:0] AluSra   = 4'b1000;
  localparam logic [3:0] AluSltu  = 4'b1001;
  localparam logic [3:0] AluLui   = 4'b1011;
  localparam logic [3:0] AluAuipc = 4'b1100;

  // ---------------------------------------------------------------------------
  // D->E pipeline register
  // ---------------------------------------------------------------------------
  logic        r_valid;
  logic        r_reg_write;
  logic        r_mem_write;
  logic        r_jump;
  logic        r_branch;
  logic [1:0]  r_result_src;
  logic [3:0]  r_alu_control;
  logic [1:0]  r_alu_src;
  logic [2:0]  r_funct3;
  logic [31:0] r_rd1;
  logic [31:0] r_rd2;
  logic [31:0] r_pc;
  logic [31:0] r_imm_ext;
  logic [31:0] r_pc_plus4;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [4:0]  r_rd;

  // Priority: reset, then flush (even when stalled), then stall.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      r_valid       <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_write   <= 1'b0;
      r_jump        <= 1'b0;
      r_branch      <= 1'b0;
      r_result_src  <= 2'b00;
      r_alu_control <= 4'b0000;
      r_alu_src     <= 2'b00;
      r_funct3      <= 3'b000;
      r_rd1         <= 32'h0;
      r_rd2         <= 32'h0;
      r_pc          <= 32'h0;
      r_imm_ext     <= 32'h0;
      r_pc_plus4    <= 32'h0;
      r_rs1         <= 5'd0;
      r_rs2         <= 5'd0;
      r_rd          <= 5'd0;
    end else if (!StallE) begin
      r_valid       <= ValidD;
      r_reg_write   <= RegWriteD;
      r_mem_write   <= MemWriteD;
      r_jump        <= JumpD;
      r_branch      <= BranchD;
      r_result_src  <= ResultSrcD;
      r_alu_control <= ALUControlD;
      r_alu_src     <= ALUSrcD;
      r_funct3      <= funct3D;
      r_rd1         <= RD1D;
      r_rd2         <= RD2D;
      r_pc          <= PCD;
      r_imm_ext     <= ImmExtD;
      r_pc_plus4    <= PCPlus4D;
      r_rs1         <= Rs1D;
      r_rs2         <= Rs2D;
      r_rd          <= RdD;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand forwarding
  // ---------------------------------------------------------------------------
  logic [31:0] w_fwd_a;
  logic [31:0] w_fwd_b;

`ifdef FORWARDING_EN
  always_comb begin
    w_fwd_a = r_rd1;
    unique case (ForwardAE)
      2'b10:   w_fwd_a = ALUResultM;
      2'b01:   w_fwd_a = ResultW;
      default: w_fwd_a = r_rd1;
    endcase
  end

  always_comb begin
    w_fwd_b = r_rd2;
    unique case (ForwardBE)
      2'b10:   w_fwd_b = ALUResultM;
      2'b01:   w_fwd_b = ResultW;
      default: w_fwd_b = r_rd2;
    endcase
  end
`else
  // Forwarding sources are deliberately ignored in this build.
  logic w_unused_fwd;
  assign w_unused_fwd = ^{ForwardAE, ForwardBE, ALUResultM, ResultW};
  assign w_fwd_a      = r_rd1;
  assign w_fwd_b      = r_rd2;
`endif

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [31:0] w_src_a;
  logic [31:0] w_src_b;
  logic [4:0]  w_shamt;
  logic [31:0] w_alu_result;

  assign w_src_a = r_alu_src[1] ? r_pc : w_fwd_a;
  assign w_src_b = r_alu_src[0] ? r_imm_ext : w_fwd_b;
  assign w_shamt = w_src_b[4:0];

  always_comb begin
    w_alu_result = 32'h0;
    unique case (r_alu_control)
      AluAdd:   w_alu_result = w_src_a + w_src_b;
      AluSub:   w_alu_result = w_src_a - w_src_b;
      AluAnd:   w_alu_result = w_src_a & w_src_b;
      AluOr:    w_alu_result = w_src_a | w_src_b;
      AluXor:   w_alu_result = w_src_a ^ w_src_b;
      AluSlt:   w_alu_result = {31'h0, $signed(w_src_a) < $signed(w_src_b)};
      AluSll:   w_alu_result = w_src_a << w_shamt;
      AluSrl:   w_alu_result = w_src_a >> w_shamt;
      AluSra:   w_alu_result = $unsigned($signed(w_src_a) >>> w_shamt);
      AluSltu:  w_alu_result = {31'h0, w_src_a < w_src_b};
      AluLui:   w_alu_result = w_src_b;
      AluAuipc: w_alu_result = w_src_a + w_src_b;
      default:  w_alu_result = 32'h0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Branch resolution
  // ---------------------------------------------------------------------------
  // Branches reuse the ALU: beq/bne via sub + zero, blt/bltu/bge/bgeu via
  // the slt/sltu result bit.
  logic w_zero;
  logic w_cond;

  assign w_zero = (w_alu_result == 32'h0);

  always_comb begin
    w_cond = 1'b0;
    unique case (r_funct3)
      3'b000:         w_cond = w_zero;
      3'b001:         w_cond = !w_zero;
      3'b100, 3'b110: w_cond = w_alu_result[0];
      3'b101, 3'b111: w_cond = !w_alu_result[0];
      default:        w_cond = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ValidE     = r_valid;
  assign RegWriteE  = r_valid & r_reg_write;
  assign MemWriteE  = r_valid & r_mem_write;
  assign ResultSrcE = r_result_src;
  assign Rs1E       = r_rs1;
  assign Rs2E       = r_rs2;
  assign RdE        = r_rd;
  assign ALUResultE = w_alu_result;
  assign WriteDataE = w_fwd_b;
  assign PCTargetE  = r_pc + r_imm_ext;
  assign PCPlus4E   = r_pc_plus4;
  assign PCSrcE     = r_valid & (r_jump | (r_branch & w_cond));

endmodule
